// File: rtl/wb_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_pipelined
// Description : Wishbone B4 slave RAM with byte-lane writes, range-checked
//               addressing (err response), fixed LATENCY in-order responses
//               and optional pipelined (one request per cycle) operation.
// Ports       : i_clk, i_rst_n (async, active-low)
//               i_wb_cyc/stb/we/addr/data/sel  - Wishbone request
//               o_wb_stall                     - request not accepted
//               o_wb_ack/o_wb_err/o_wb_data    - registered response
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_pipelined #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int LATENCY     = 1,
    parameter int PIPELINED   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
    output logic                    o_wb_stall,
    output logic                    o_wb_ack,
    output logic                    o_wb_err,
    output logic [DATA_WIDTH-1:0]   o_wb_data
);

    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_BYTES);
    localparam int c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam int c_HI_LSB = c_OFF_W + c_IDX_W;

    // Storage is intentionally left without reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Response pipeline; stage LATENCY-1 drives the outputs directly.
    logic [LATENCY-1:0]    r_ack_pipe;
    logic [LATENCY-1:0]    r_err_pipe;
    logic [DATA_WIDTH-1:0] r_dat_pipe [LATENCY];

    logic                  w_stall;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic [c_IDX_W-1:0]    w_idx;

    assign w_idx = i_wb_addr[c_HI_LSB-1:c_OFF_W];

    // Any set address bit above the word index makes the request out of range.
    generate
        if (ADDR_WIDTH > c_HI_LSB) begin : g_hi_chk
            assign w_in_range = ~|i_wb_addr[ADDR_WIDTH-1:c_HI_LSB];
        end else begin : g_no_hi
            assign w_in_range = 1'b1;
        end
    endgenerate

    // Byte-offset bits carry no meaning for a word-wide RAM.
    generate
        if (c_OFF_W > 0) begin : g_off_bits
            logic w_unused_off;
            assign w_unused_off = ^i_wb_addr[c_OFF_W-1:0];
        end
    endgenerate

    // Classic mode holds stall for as long as any response is in flight,
    // which covers acceptance through the cycle the response is driven.
    generate
        if (PIPELINED != 0) begin : g_pipelined
            assign w_stall = 1'b0;
        end else begin : g_classic
            assign w_stall = |(r_ack_pipe | r_err_pipe);
        end
    endgenerate

    assign w_accept = i_rst_n & i_wb_cyc & i_wb_stb & ~w_stall;
    assign w_wr     = w_accept & i_wb_we & w_in_range;
    assign w_rd     = w_accept & ~i_wb_we & w_in_range;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (i_wb_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack_pipe <= '0;
            r_err_pipe <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_dat_pipe[s] <= '0;
            end
        end else if (!i_wb_cyc) begin
            // Master abandoned the cycle: drop everything still in flight.
            r_ack_pipe <= '0;
            r_err_pipe <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_dat_pipe[s] <= '0;
            end
        end else begin
            r_ack_pipe[0] <= w_accept & w_in_range;
            r_err_pipe[0] <= w_accept & ~w_in_range;
            // Read data is sampled before this edge's write could land,
            // but only one request is accepted per edge so no hazard exists.
            r_dat_pipe[0] <= w_rd ? r_mem[w_idx] : '0;
            for (int s = 1; s < LATENCY; s++) begin
                r_ack_pipe[s] <= r_ack_pipe[s-1];
                r_err_pipe[s] <= r_err_pipe[s-1];
                r_dat_pipe[s] <= r_dat_pipe[s-1];
            end
        end
    end

    assign o_wb_stall = w_stall;
    assign o_wb_ack   = r_ack_pipe[LATENCY-1];
    assign o_wb_err   = r_err_pipe[LATENCY-1];
    assign o_wb_data  = r_dat_pipe[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ram_pipelined
// Description : Self-checking bench for wb_ram_pipelined. Three instances:
//               u_p2 (LATENCY=2, pipelined), u_p3 (LATENCY=3, pipelined),
//               u_c2 (LATENCY=2, classic). Expected responses are queued
//               when requests are issued and popped when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_pipelined;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;
    localparam int SW    = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    logic [2:0]    cyc, stb, stall, ack, err;
    logic [DW-1:0] rdata0, rdata1, rdata2;

    int total   = 0;
    int bad     = 0;
    int cnt     = 0;
    int dut_sel = 0;
    int rsp_n   = 0;
    int err_n   = 0;
    logic [DW-1:0] last_data;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    int            rsp_cyc[$];
    logic [DW-1:0] mdl [3][DEPTH];

    int        first_acc, n0, e0, nacc;
    logic      s_st;
    logic [5:0] stall_seen;

    wb_ram_pipelined #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW),
                       .LATENCY(2), .PIPELINED(1)) u_p2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_data(rdata0));

    wb_ram_pipelined #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW),
                       .LATENCY(3), .PIPELINED(1)) u_p3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_data(rdata1));

    wb_ram_pipelined #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW),
                       .LATENCY(2), .PIPELINED(0)) u_c2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[2]), .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_wb_data(rdata2));

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [AW-1:0] a);
        return (a / SW) < DEPTH;
    endfunction

    // Queue the response the reference model predicts for one accepted request.
    task automatic model_req(input int d, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] dat, input logic [SW-1:0] s);
        rsp_t x;
        if (!in_rng(a)) begin
            x.err = 1'b1; x.data = '0;
        end else if (w) begin
            for (int b = 0; b < SW; b++)
                if (s[b]) mdl[d][a[9:2]][8*b +: 8] = dat[8*b +: 8];
            x.err = 1'b0; x.data = '0;
        end else begin
            x.err = 1'b0; x.data = mdl[d][a[9:2]];
        end
        exp_q.push_back(x);
    endtask

    // Single request to a pipelined instance (never stalls).
    task automatic req(input int d, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] dat, input logic [SW-1:0] s, input bit push);
        cyc[d] = 1'b1; stb[d] = 1'b1; we = w; addr = a; wdata = dat; sel = s;
        chk("stall_pipelined", stall[d], 1'b0);
        @(posedge clk); #1;
        stb[d] = 1'b0;
        if (push) model_req(d, w, a, dat, s);
    endtask

    // Request to the classic instance: hold stb until the stall-free edge.
    task automatic creq(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] dat, input logic [SW-1:0] s);
        bit acc = 0;
        logic st;
        cyc[2] = 1'b1; stb[2] = 1'b1; we = w; addr = a; wdata = dat; sel = s;
        for (int i = 0; i < 10 && !acc; i++) begin
            st = stall[2];
            @(posedge clk); #1;
            if (!st) acc = 1;
        end
        stb[2] = 1'b0;
        chk("creq_accept", acc, 1'b1);
        if (acc) model_req(2, w, a, dat, s);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    // Response monitor and scoreboard.
    always @(negedge clk) begin : mon
        logic a, e;
        logic [DW-1:0] d;
        rsp_t x;
        a = ack[dut_sel];
        e = err[dut_sel];
        d = (dut_sel == 0) ? rdata0 : (dut_sel == 1) ? rdata1 : rdata2;
        if (a || e) begin
            rsp_n++;
            if (e) err_n++;
            if (a) last_data = d;
            rsp_cyc.push_back(cnt);
            chk("ack_err_exclusive", a & e, 1'b0);
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_rsp observed=ack%0b_err%0b expected=none", a, e);
            end
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("rsp_err", e, x.err);
                chk("rsp_ack", a, !x.err);
                chk("rsp_data", d, x.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cyc = '0; stb = '0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 3'b000);
        chk("rst_err", err, 3'b000);
        chk("rst_stall", stall, 3'b000);
        chk("rst_data0", rdata0, 0);
        chk("rst_data1", rdata1, 0);
        chk("rst_data2", rdata2, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte lanes.
        dut_sel = 0;
        req(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 1);
        req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1);
        req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1);
        drain("drain_bytelane");
        chk("bytelane_read", last_data, 32'hAA22CC44);

        // Pipelined burst, LATENCY=2.
        for (int i = 0; i < 4; i++) req(0, 1'b1, 32'(4*i), 32'(i+1), 4'hF, 1);
        drain("drain_preload");
        rsp_cyc.delete();
        req(0, 1'b0, 32'h00, 32'h0, 4'hF, 1);
        first_acc = cnt;
        req(0, 1'b0, 32'h04, 32'h0, 4'hF, 1);
        req(0, 1'b0, 32'h08, 32'h0, 4'hF, 1);
        req(0, 1'b0, 32'h0C, 32'h0, 4'hF, 1);
        drain("drain_burst");
        chk("burst_count", rsp_cyc.size(), 4);
        chk("burst_last_data", last_data, 32'h4);
        if (rsp_cyc.size() == 4) begin
            chk("burst_first_latency", rsp_cyc[0] - first_acc, 1);
            for (int i = 1; i < 4; i++) chk("burst_train", rsp_cyc[i] - rsp_cyc[i-1], 1);
        end

        // Out of range.
        e0 = err_n;
        n0 = rsp_n;
        req(0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1);
        req(0, 1'b0, 32'h400, 32'h0, 4'hF, 1);
        req(0, 1'b0, 32'h000, 32'h0, 4'hF, 1);
        drain("drain_oor");
        chk("oor_err_pulses", err_n - e0, 2);
        chk("oor_rsp_total", rsp_n - n0, 3);
        chk("oor_word0_intact", last_data, 32'h1);

        // Reset mid-read: response must never appear.
        n0 = rsp_n;
        req(0, 1'b0, 32'h04, 32'h0, 4'hF, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ack", ack[0], 1'b0);
        chk("midrst_err", err[0], 1'b0);
        chk("midrst_data", rdata0, 0);
        chk("midrst_stall", stall[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_dropped", rsp_n - n0, 0);
        req(0, 1'b0, 32'h08, 32'h0, 4'hF, 1);
        drain("drain_after_rst");
        chk("after_rst_read", last_data, 32'h3);
        cyc[0] = 1'b0;

        // Abort on LATENCY=3 pipelined instance.
        dut_sel = 1;
        req(1, 1'b1, 32'h00, 32'h100, 4'hF, 1);
        req(1, 1'b1, 32'h04, 32'h200, 4'hF, 1);
        req(1, 1'b1, 32'h08, 32'h300, 4'hF, 1);
        drain("drain_abort_preload");
        n0 = rsp_n;
        req(1, 1'b0, 32'h00, 32'h0, 4'hF, 0);
        req(1, 1'b0, 32'h04, 32'h0, 4'hF, 0);
        cyc[1] = 1'b0;
        @(posedge clk); #1;
        repeat (5) @(negedge clk);
        chk("abort_no_rsp", rsp_n - n0, 0);
        n0 = rsp_n;
        req(1, 1'b0, 32'h08, 32'h0, 4'hF, 1);
        drain("drain_abort_new");
        chk("abort_new_one_rsp", rsp_n - n0, 1);
        chk("abort_new_data", last_data, 32'h300);
        cyc[1] = 1'b0;

        // Classic mode, LATENCY=2.
        dut_sel = 2;
        creq(1'b1, 32'h00, 32'hA5A50001, 4'hF);
        creq(1'b1, 32'h04, 32'h5A5A0002, 4'hF);
        drain("drain_classic_preload");
        rsp_cyc.delete();
        n0 = rsp_n;
        nacc = 0;
        cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b0; addr = 32'h00; sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            s_st = stall[2];
            @(posedge clk); #1;
            if (!s_st) begin
                model_req(2, 1'b0, addr, 32'h0, 4'hF);
                nacc++;
                addr = 32'h04;
            end
            stall_seen[k] = stall[2];
        end
        stb[2] = 1'b0;
        chk("classic_stall_pattern", stall_seen, 6'b011011);
        chk("classic_accepts", nacc, 2);
        drain("drain_classic");
        chk("classic_acks", rsp_n - n0, 2);
        chk("classic_last_data", last_data, 32'h5A5A0002);
        if (rsp_cyc.size() == 2) chk("classic_ack_gap", rsp_cyc[1] - rsp_cyc[0], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_ram_pipelined.md
# wb_ram_pipelined

Parametrised Wishbone B4 slave RAM: the next-generation combined instruction/data memory for the multi-cycle RISC-V CPU. It adds configurable data width, depth and read latency, and a pipelined mode accepting one request per cycle. It also provides byte-lane writes, range-checked addressing with error responses, and in-order fixed-latency responses that are flushed when the master abandons a cycle.

## Interface
- DATA_WIDTH, 32, data bus width in bits; multiple of 8, 8..128
- DEPTH_WORDS, 256, number of DATA_WIDTH words; power of two
- ADDR_WIDTH, 32, width of byte address bus; ≥ clog2(DEPTH_WORDS*DATA_WIDTH/8)
- LATENCY, 1, cycles from request acceptance to ack/err; 1..4
- PIPELINED, 1, 1 = B4 pipelined (back-to-back requests); 0 = one outstanding request at a time

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_cyc  in  1  bus cycle active
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  ADDR_WIDTH  byte address
- i_wb_data  in  DATA_WIDTH  write data
- i_wb_sel  in  DATA_WIDTH/8  byte-lane enables; bit n covers data[8n+7:8n]
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_ack  out  1  successful response, one cycle per accepted request
- o_wb_err  out  1  error response for an out-of-range request
- o_wb_data  out  DATA_WIDTH  read data, valid when o_wb_ack is high for a read

## Operation
- Accept: request accepted on a rising edge when i_wb_cyc & i_wb_stb & !o_wb_stall.
- Word index = i_wb_addr >> clog2(DATA_WIDTH/8); low byte-offset bits are ignored.
- In range: word index < DEPTH_WORDS with all upper address bits zero. Otherwise the request is out of range.
- Write, in range: the array is updated at the accepting edge for each lane with i_wb_sel set. Unselected lanes are unchanged. i_wb_sel = 0 is legal, changes nothing, and still acks.
- Read, in range: the array is sampled at the accepting edge. All lanes are returned regardless of i_wb_sel.
- Out of range: no array access. The response is o_wb_err=1, o_wb_ack=0, o_wb_data=0.
- Response pipeline: a LATENCY-deep shift register holds {valid, is_err, is_read, data}.
  - Responses return strictly in acceptance order.
  - Exactly one response per accepted request.
  - o_wb_ack and o_wb_err are never high together.
- For write responses, o_wb_data = 0.
- PIPELINED=1: o_wb_stall is constant 0.
- PIPELINED=0: o_wb_stall = 1 while any request is in flight, from the edge after acceptance through the cycle its response is driven. It returns to 0 in the cycle after the response.
- Abort: when i_wb_cyc is low, all in-flight entries are invalidated at that edge. No ack/err is issued for them.
  - Writes already accepted remain committed.
  - stb without cyc is ignored.
- Memory contents are not reset and are X/undefined after power-up. Initialisation is outside this block's behaviour.
- Read-after-write to the same word, on consecutive accepted requests, returns the new data.

## Timing
- Reset (i_rst_n low, asynchronous): o_wb_ack=0, o_wb_err=0, o_wb_data=0, pipeline invalid, o_wb_stall=0.
  - Reset assertion mid-transaction drops all pending responses immediately.
  - Deassertion is synchronised by the system. The first request may be accepted at the first rising edge with i_rst_n high.
- A request accepted at edge N produces its response during the cycle following edge N+LATENCY-1, i.e. ack is visible LATENCY cycles after acceptance (LATENCY=1: ack in the cycle after the request).
- PIPELINED=1 throughput: 1 request/cycle sustained; acks form a matching contiguous train.
- PIPELINED=0 throughput: 1 request per LATENCY+1 cycles.
- o_wb_ack, o_wb_err and o_wb_data are registered outputs. o_wb_stall is registered or derived from registers only, never combinationally from i_wb_*.

## Test plan
- Reset mid-read, DATA_WIDTH=32, LATENCY=2: accept read, assert i_rst_n low next cycle -> ack never appears; all outputs 0 while in reset.
- Byte lanes: write 0xAABBCCDD to byte addr 0x10 with sel=4'hF, then write 0x11223344 with sel=4'b0101, then read 0x10 -> o_wb_data=0xAA22CC44 with ack.
- Pipelined burst, LATENCY=2: reads of 0x00, 0x04, 0x08, 0x0C on 4 consecutive cycles (preloaded 1, 2, 3, 4) -> stall stays 0; ack high 4 consecutive cycles starting 2 cycles after the first accept; data 1, 2, 3, 4 in order.
- Out of range, DEPTH_WORDS=256: write 0x12345678 to 0x400, then read 0x400 -> two err pulses, no ack; read of 0x000 is unaffected.
- Abort: PIPELINED=1, LATENCY=3, issue 2 reads, drop i_wb_cyc one cycle later -> zero acks; a new read after cyc returns gets exactly one ack.
- Classic mode: PIPELINED=0, LATENCY=2, hold stb high over 6 cycles with addresses 0x00, 0x04 -> stall high 2 cycles after each acceptance; exactly 2 acks, 3 cycles apart.
